// File: rtl/wr_slot_tracker.sv
// wr_slot_tracker: tracks one outstanding AXI write slot.
// The slot is allocated on an AW handshake and follows the transaction through the W-data
// phase and then the B-response phase. Each phase has its own cycle budget. The slot raises
// a sticky timeout tagged with the phase, or a beat-count protocol error. It frees itself on
// the matching B handshake.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   alloc_i                      AW handshake assigned to this slot
//   aw_id_i, aw_len_i            AWID / AWLEN, latched on alloc
//   w_budget_i, b_budget_i       per-phase cycle budgets, latched on alloc
//   w_valid_i/w_ready_i/w_last_i W channel; w_head_i marks this slot oldest in W order
//   b_valid_i/b_ready_i/b_id_i   B channel; b_head_i marks this slot oldest for its ID
//   clear_i                      release a slot that has timed out
//   busy_o, state_o, id_o, timer_o, timeout_o, timeout_phase_o, proto_err_o,
//   alloc_err_o, done_o          registered status outputs
module wr_slot_tracker #(
  parameter int unsigned CntWidth = 8,
  parameter int unsigned IdWidth  = 4,
  parameter int unsigned LenWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                alloc_i,
  input  logic [IdWidth-1:0]  aw_id_i,
  input  logic [LenWidth-1:0] aw_len_i,
  input  logic [CntWidth-1:0] w_budget_i,
  input  logic [CntWidth-1:0] b_budget_i,
  input  logic                w_valid_i,
  input  logic                w_ready_i,
  input  logic                w_last_i,
  input  logic                w_head_i,
  input  logic                b_valid_i,
  input  logic                b_ready_i,
  input  logic [IdWidth-1:0]  b_id_i,
  input  logic                b_head_i,
  input  logic                clear_i,
  output logic                busy_o,
  output logic [1:0]          state_o,
  output logic [IdWidth-1:0]  id_o,
  output logic [CntWidth-1:0] timer_o,
  output logic                timeout_o,
  output logic                timeout_phase_o,
  output logic                proto_err_o,
  output logic                alloc_err_o,
  output logic                done_o
);

  typedef enum logic [1:0] {
    StFree    = 2'd0,
    StWData   = 2'd1,
    StWResp   = 2'd2,
    StTimeout = 2'd3
  } state_e;

  // One extra bit so an over-long burst is still counted past len.
  localparam int unsigned BeatWidth = LenWidth + 1;

  state_e                state_q, state_d;
  logic [IdWidth-1:0]    id_q, id_d;
  logic [LenWidth-1:0]   len_q, len_d;
  logic [CntWidth-1:0]   b_budget_q, b_budget_d;
  logic [CntWidth-1:0]   timer_q, timer_d;
  logic [BeatWidth-1:0]  beats_q, beats_d;
  logic                  proto_err_q, proto_err_d;
  logic                  phase_q, phase_d;
  logic                  alloc_err_q, alloc_err_d;
  logic                  done_q, done_d;

  logic w_hs, b_hs;
  logic timer_zero, beats_at_len, beats_sat;

  assign w_hs         = w_valid_i & w_ready_i & w_head_i;
  assign b_hs         = b_valid_i & b_ready_i & b_head_i & (b_id_i == id_q);
  assign timer_zero   = (timer_q == '0);
  assign beats_at_len = (beats_q == {1'b0, len_q});
  assign beats_sat    = (beats_q == {BeatWidth{1'b1}});

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    len_d       = len_q;
    b_budget_d  = b_budget_q;
    timer_d     = timer_q;
    beats_d     = beats_q;
    proto_err_d = proto_err_q;
    phase_d     = phase_q;
    // Any alloc outside FREE is rejected, including one that coincides with clear_i.
    alloc_err_d = alloc_i & (state_q != StFree);
    done_d      = 1'b0;

    unique case (state_q)
      StFree: begin
        if (alloc_i) begin
          id_d        = aw_id_i;
          len_d       = aw_len_i;
          b_budget_d  = b_budget_i;
          timer_d     = w_budget_i;
          beats_d     = '0;
          proto_err_d = 1'b0;
          state_d     = StWData;
        end
      end
      StWData: begin
        if (w_hs && w_last_i) begin
          if (!beats_at_len) proto_err_d = 1'b1;
          timer_d = b_budget_q;
          state_d = StWResp;
        end else if (w_hs) begin
          if (!beats_sat) beats_d = beats_q + BeatWidth'(1);
          if (beats_at_len) proto_err_d = 1'b1;
          // A beat never refills the timer; at zero it simply parks until the next idle cycle.
          if (!timer_zero) timer_d = timer_q - CntWidth'(1);
        end else if (timer_zero) begin
          state_d = StTimeout;
          phase_d = 1'b0;
        end else begin
          timer_d = timer_q - CntWidth'(1);
        end
      end
      StWResp: begin
        if (b_hs) begin
          state_d = StFree;
          done_d  = 1'b1;
        end else if (timer_zero) begin
          state_d = StTimeout;
          phase_d = 1'b1;
        end else begin
          timer_d = timer_q - CntWidth'(1);
        end
      end
      StTimeout: begin
        if (clear_i) state_d = StFree;
      end
      default: state_d = StFree;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StFree;
      id_q        <= '0;
      len_q       <= '0;
      b_budget_q  <= '0;
      timer_q     <= '0;
      beats_q     <= '0;
      proto_err_q <= 1'b0;
      phase_q     <= 1'b0;
      alloc_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      len_q       <= len_d;
      b_budget_q  <= b_budget_d;
      timer_q     <= timer_d;
      beats_q     <= beats_d;
      proto_err_q <= proto_err_d;
      phase_q     <= phase_d;
      alloc_err_q <= alloc_err_d;
      done_q      <= done_d;
    end
  end

  assign busy_o          = (state_q != StFree);
  assign state_o         = state_q;
  assign id_o            = id_q;
  assign timer_o         = timer_q;
  assign timeout_o       = (state_q == StTimeout);
  assign timeout_phase_o = phase_q;
  assign proto_err_o     = proto_err_q;
  assign alloc_err_o     = alloc_err_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_wr_slot_tracker.sv
// Bench for wr_slot_tracker: directed scenarios with explicit expected values, then
// randomized traffic compared every cycle against a cycle-level behavioural model.
module tb_wr_slot_tracker;

  localparam int CW = 8;
  localparam int IW = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst, alloc, w_valid, w_ready, w_last, w_head;
  logic          b_valid, b_ready, b_head, clear;
  logic [IW-1:0] aw_id, b_id;
  logic [LW-1:0] aw_len;
  logic [CW-1:0] w_budget, b_budget;

  logic          busy, timeout, phase, perr, aerr, done;
  logic [1:0]    state;
  logic [IW-1:0] id;
  logic [CW-1:0] timer;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: plain integers, one update per clock edge.
  int m_state, m_id, m_len, m_bbud, m_timer, m_beats, m_perr, m_phase, m_aerr, m_done;

  always #5 clk = ~clk;

  wr_slot_tracker #(.CntWidth(CW), .IdWidth(IW), .LenWidth(LW)) dut (
    .clk_i(clk), .rst_i(rst), .alloc_i(alloc), .aw_id_i(aw_id), .aw_len_i(aw_len),
    .w_budget_i(w_budget), .b_budget_i(b_budget),
    .w_valid_i(w_valid), .w_ready_i(w_ready), .w_last_i(w_last), .w_head_i(w_head),
    .b_valid_i(b_valid), .b_ready_i(b_ready), .b_id_i(b_id), .b_head_i(b_head),
    .clear_i(clear),
    .busy_o(busy), .state_o(state), .id_o(id), .timer_o(timer), .timeout_o(timeout),
    .timeout_phase_o(phase), .proto_err_o(perr), .alloc_err_o(aerr), .done_o(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_step();
    bit whs, bhs;
    int max_beats;
    max_beats = (1 << (LW + 1)) - 1;
    whs = w_valid && w_ready && w_head;
    bhs = b_valid && b_ready && b_head && (int'(b_id) == m_id);
    if (rst) begin
      m_state = 0; m_id = 0; m_len = 0; m_bbud = 0; m_timer = 0;
      m_beats = 0; m_perr = 0; m_phase = 0; m_aerr = 0; m_done = 0;
      return;
    end
    m_aerr = (alloc && m_state != 0) ? 1 : 0;
    m_done = 0;
    case (m_state)
      0: if (alloc) begin
        m_id = int'(aw_id); m_len = int'(aw_len); m_bbud = int'(b_budget);
        m_timer = int'(w_budget); m_beats = 0; m_perr = 0; m_state = 1;
      end
      1: begin
        if (whs && w_last) begin
          if (m_beats != m_len) m_perr = 1;
          m_timer = m_bbud;
          m_state = 2;
        end else if (whs) begin
          if (m_beats == m_len) m_perr = 1;
          if (m_beats < max_beats) m_beats = m_beats + 1;
          if (m_timer > 0) m_timer = m_timer - 1;
        end else if (m_timer == 0) begin
          m_state = 3; m_phase = 0;
        end else begin
          m_timer = m_timer - 1;
        end
      end
      2: begin
        if (bhs) begin
          m_state = 0; m_done = 1;
        end else if (m_timer == 0) begin
          m_state = 3; m_phase = 1;
        end else begin
          m_timer = m_timer - 1;
        end
      end
      default: if (clear) m_state = 0;
    endcase
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_state));
    chk("busy", 32'(busy), (m_state != 0) ? 32'd1 : 32'd0);
    chk("id", 32'(id), 32'(m_id));
    chk("timer", 32'(timer), 32'(m_timer));
    chk("timeout", 32'(timeout), (m_state == 3) ? 32'd1 : 32'd0);
    chk("phase", 32'(phase), 32'(m_phase));
    chk("proto_err", 32'(perr), 32'(m_perr));
    chk("alloc_err", 32'(aerr), 32'(m_aerr));
    chk("done", 32'(done), 32'(m_done));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    alloc = 0; w_valid = 0; w_ready = 0; w_last = 0; w_head = 0;
    b_valid = 0; b_ready = 0; b_head = 0; clear = 0; rst = 0;
  endtask

  task automatic do_alloc(input int i, input int l, input int wb, input int bb);
    alloc = 1; aw_id = IW'(i); aw_len = LW'(l); w_budget = CW'(wb); b_budget = CW'(bb);
  endtask

  task automatic w_beat(input bit last, input bit head);
    w_valid = 1; w_ready = 1; w_last = last; w_head = head;
  endtask

  task automatic b_resp(input int i);
    b_valid = 1; b_ready = 1; b_head = 1; b_id = IW'(i);
  endtask

  initial begin
    idle_inputs();
    aw_id = '0; aw_len = '0; w_budget = '0; b_budget = '0; b_id = '0;
    rst = 1;
    tick(); tick();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_timer", 32'(timer), 32'd0);
    rst = 0;

    // Scenario 1: len=3, four beats, then B at cycle 7.
    do_alloc(5, 3, 10, 5);
    tick();                                     // cycle 1
    alloc = 0;
    chk("s1_timer_c1", 32'(timer), 32'd10);
    w_beat(0, 1);
    tick(); tick(); tick();                     // cycle 4
    chk("s1_timer_c4", 32'(timer), 32'd7);
    w_last = 1;
    tick();                                     // cycle 5
    idle_inputs();
    chk("s1_state_c5", 32'(state), 32'd2);
    chk("s1_timer_c5", 32'(timer), 32'd5);
    tick(); tick();                             // cycle 7
    b_resp(5);
    tick();                                     // cycle 8
    idle_inputs();
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_free", 32'(state), 32'd0);
    chk("s1_perr", 32'(perr), 32'd0);
    chk("s1_tmo", 32'(timeout), 32'd0);
    tick();
    chk("s1_done_pulse", 32'(done), 32'd0);

    // Scenario 2: W-phase timeout, then clear.
    do_alloc(1, 0, 3, 4);
    tick(); alloc = 0;
    chk("s2_t3", 32'(timer), 32'd3);
    tick(); chk("s2_t2", 32'(timer), 32'd2);
    tick(); chk("s2_t1", 32'(timer), 32'd1);
    tick(); chk("s2_t0", 32'(timer), 32'd0);
    tick();                                     // cycle 5
    chk("s2_state", 32'(state), 32'd3);
    chk("s2_tmo", 32'(timeout), 32'd1);
    chk("s2_phase", 32'(phase), 32'd0);
    tick(); tick();                             // cycle 7
    clear = 1;
    tick(); clear = 0;                          // cycle 8
    chk("s2_cleared", 32'(state), 32'd0);
    chk("s2_no_done", 32'(done), 32'd0);

    // Scenario 3: short burst, wrong-ID B ignored, B-phase timeout.
    do_alloc(3, 1, 6, 2);
    tick(); alloc = 0;
    w_beat(1, 1);
    tick(); idle_inputs();
    chk("s3_perr", 32'(perr), 32'd1);
    chk("s3_wresp", 32'(state), 32'd2);
    b_resp(4);
    tick(); tick(); idle_inputs();
    chk("s3_wrong_id", 32'(state), 32'd2);
    chk("s3_t0", 32'(timer), 32'd0);
    tick();
    chk("s3_tmo", 32'(timeout), 32'd1);
    chk("s3_phase", 32'(phase), 32'd1);
    clear = 1; alloc = 1;                       // alloc together with clear is rejected
    tick(); idle_inputs();
    chk("s3_clear", 32'(state), 32'd0);
    chk("s3_aerr", 32'(aerr), 32'd1);

    // Scenario 4: B handshake in the cycle the W_RESP timer reaches 0.
    do_alloc(2, 0, 5, 1);
    tick(); alloc = 0;
    w_beat(1, 1);
    tick(); idle_inputs();
    tick();
    chk("s4_t0", 32'(timer), 32'd0);
    b_resp(2);
    tick(); idle_inputs();
    chk("s4_free", 32'(state), 32'd0);
    chk("s4_done", 32'(done), 32'd1);
    chk("s4_tmo", 32'(timeout), 32'd0);

    // Scenario 5: alloc while busy, then reset mid-W_RESP.
    do_alloc(6, 2, 9, 9);
    tick();
    do_alloc(9, 7, 1, 1);
    tick(); alloc = 0;
    chk("s5_aerr", 32'(aerr), 32'd1);
    chk("s5_id_held", 32'(id), 32'd6);
    w_beat(0, 1);
    tick(); tick();
    w_last = 1;
    tick(); idle_inputs();
    chk("s5_len_held", 32'(perr), 32'd0);
    chk("s5_wresp", 32'(state), 32'd2);
    rst = 1; b_resp(6);
    tick(); idle_inputs();
    chk("s5_rst_state", 32'(state), 32'd0);
    chk("s5_rst_done", 32'(done), 32'd0);
    chk("s5_rst_id", 32'(id), 32'd0);

    // Scenario 6: beats without head are not counted, timer keeps running.
    do_alloc(7, 0, 4, 3);
    tick(); alloc = 0;
    w_beat(1, 0);
    tick(); chk("s6_t3", 32'(timer), 32'd3);
    tick(); chk("s6_t2", 32'(timer), 32'd2);
    chk("s6_state", 32'(state), 32'd1);
    w_head = 1;
    tick(); idle_inputs();
    chk("s6_perr", 32'(perr), 32'd0);
    rst = 1; tick(); rst = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      alloc    = ($urandom_range(0, 3) == 0);
      aw_id    = IW'($urandom_range(0, 3));
      aw_len   = LW'($urandom_range(0, 3));
      w_budget = CW'($urandom_range(0, 6));
      b_budget = CW'($urandom_range(0, 6));
      w_valid  = ($urandom_range(0, 2) != 0);
      w_ready  = ($urandom_range(0, 3) != 0);
      w_last   = ($urandom_range(0, 2) == 0);
      w_head   = ($urandom_range(0, 4) != 0);
      b_valid  = ($urandom_range(0, 2) == 0);
      b_ready  = ($urandom_range(0, 3) != 0);
      b_head   = ($urandom_range(0, 4) != 0);
      b_id     = IW'($urandom_range(0, 3));
      clear    = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wr_slot_tracker.md
Name: wr_slot_tracker

Overview:
- Per-slot write-transaction tracker in the AXI monitor; the write-channel counterpart of the per-slot read timeout counter.
- One instance owns one outstanding-write slot. It is allocated on an AW handshake and follows the transaction through the W-data phase and the B-response phase.
- Each phase has its own cycle budget. The slot raises a sticky timeout (with phase tag) or a protocol error, and frees itself on the matching B handshake.
- The parent monitor instantiates N copies and supplies the head-of-queue qualifiers (W order, B per-ID order).

Parameters:
- CntWidth, 8, width of the phase timer and of the budget inputs
- IdWidth, 4, width of the AXI ID
- LenWidth, 8, width of AxLEN (beats = len+1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- alloc_i  in  1  AW handshake assigned to this slot
- aw_id_i  in  IdWidth  AWID, latched on alloc
- aw_len_i  in  LenWidth  AWLEN, latched on alloc
- w_budget_i  in  CntWidth  W-phase budget, latched on alloc
- b_budget_i  in  CntWidth  B-phase budget, latched on alloc
- w_valid_i, w_ready_i, w_last_i  in  1 each  W channel
- w_head_i  in  1  this slot is the oldest slot in W order
- b_valid_i, b_ready_i  in  1 each  B channel
- b_id_i  in  IdWidth  BID
- b_head_i  in  1  this slot is the oldest slot for its ID
- clear_i  in  1  release a TIMEOUT slot
- busy_o  out  1  slot not FREE
- state_o  out  2  FREE=0, W_DATA=1, W_RESP=2, TIMEOUT=3
- id_o  out  IdWidth  latched ID
- timer_o  out  CntWidth  current timer
- timeout_o  out  1  state==TIMEOUT
- timeout_phase_o  out  1  0 = timed out in W_DATA, 1 = timed out in W_RESP
- proto_err_o  out  1  sticky beat-count mismatch
- alloc_err_o  out  1  one-cycle pulse: alloc_i while not FREE
- done_o  out  1  one-cycle pulse on B completion

Behaviour:
- Reset (sync, rst_i=1 at a clock edge):
  - state FREE; all registers and outputs 0.
  - Reset overrides every other input, including mid-transaction.
- Qualified events:
  - w_hs = w_valid_i & w_ready_i & w_head_i
  - b_hs = b_valid_i & b_ready_i & b_head_i & (b_id_i == id_q)
- FREE:
  - On alloc_i: latch id, len, b_budget; timer <= w_budget_i; beats <= 0; proto_err cleared; next state W_DATA.
- W_DATA, evaluated in this priority order:
  1. w_hs & w_last_i:
     - proto_err <= 1 if beats != len.
     - timer <= latched b_budget; next state W_RESP.
  2. w_hs & !w_last_i:
     - beats <= beats+1.
     - proto_err <= 1 if beats == len (non-last on the final beat).
     - timer <= timer-1 if timer != 0.
  3. No w_hs, timer == 0: next state TIMEOUT, phase=0.
  4. Otherwise: timer <= timer-1.
- Timer rules (W_DATA):
  - A non-last beat does not reset the timer; the budget covers the whole phase.
  - On a non-last beat with timer==0, the timer stays 0 and the state stays W_DATA; timeout fires on the next cycle with no completing event.
  - The beat counter saturates at 2^(LenWidth+1)-1.
- W_RESP, evaluated in this priority order:
  1. b_hs: next state FREE; done_o=1 for the following cycle.
  2. timer == 0: next state TIMEOUT, phase=1.
  3. Otherwise: timer <= timer-1.
- The completing event always wins over timeout in the same cycle.
- W beats or B responses arriving in FREE or TIMEOUT are ignored by this slot.
- TIMEOUT:
  - State, id, phase and proto_err hold.
  - clear_i moves the slot to FREE (no done_o).
  - alloc_i in the same cycle as clear_i is rejected with alloc_err_o.
- alloc_i in any non-FREE state: ignored; alloc_err_o pulses the next cycle.
- Output timing: all outputs are registered. Budget B allows B decrement cycles, then timeout on the next cycle; timeout_o is visible one cycle after that.
- No combinational paths from inputs to outputs.

Test Plan:
- Alloc at cycle 0 (len=3, w_budget=10, b_budget=5), w_hs at cycles 1-4 with last at 4, b_hs (matching ID, head) at cycle 7:
  - timer=7 at cycle 4; state=W_RESP, timer=5 at cycle 5.
  - done_o=1 at cycle 8; state FREE; proto_err_o=0; timeout_o=0.
- Alloc (w_budget=3), no W traffic:
  - timer 3,2,1,0 in cycles 1-4.
  - state=TIMEOUT, timeout_o=1, timeout_phase_o=0 at cycle 5.
  - clear_i at cycle 7 -> FREE at cycle 8.
- Alloc (len=1), W last on the first beat: proto_err_o=1, state W_RESP; b_hs with wrong ID ignored; b_budget=2 expires -> TIMEOUT, phase=1.
- b_hs in the same cycle the W_RESP timer is 0 -> FREE + done_o, no timeout.
- alloc_i while in W_DATA -> alloc_err_o pulse, latched id/len unchanged; rst_i mid-W_RESP -> next cycle FREE, all outputs 0, no done_o.
- w_valid/w_ready/w_last=1 with w_head_i=0 -> beats unchanged, timer decrements.
